// File: rtl/hwpe_stream_tcdm_rr_arbiter.sv
// rtl/hwpe_stream_tcdm_rr_arbiter.sv - round-robin TCDM arbiter with in-order response ID FIFO
// Optional granted-transaction counter: HWPE_STREAM_TCDM_ARB_PERF_CNT_EN
module hwpe_stream_tcdm_rr_arbiter #(
   parameter int unsigned NB_IN_CHAN      = 4,
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter int unsigned ID_W            = $clog2(NB_IN_CHAN)
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        clear_i,
   input  logic [NB_IN_CHAN-1:0]       in_req_i,
   input  logic [NB_IN_CHAN-1:0][31:0] in_add_i,
   input  logic [NB_IN_CHAN-1:0]       in_wen_i,
   input  logic [NB_IN_CHAN-1:0][3:0]  in_be_i,
   input  logic [NB_IN_CHAN-1:0][31:0] in_data_i,
   output logic [NB_IN_CHAN-1:0]       in_gnt_o,
   output logic [NB_IN_CHAN-1:0][31:0] in_r_data_o,
   output logic [NB_IN_CHAN-1:0]       in_r_valid_o,
   output logic                        out_req_o,
   output logic [31:0]                 out_add_o,
   output logic                        out_wen_o,
   output logic [3:0]                  out_be_o,
   output logic [31:0]                 out_data_o,
   input  logic                        out_gnt_i,
   input  logic [31:0]                 out_r_data_i,
   input  logic                        out_r_valid_i,
   output logic                        idle_o,
   output logic                        err_o,
   output logic [31:0]                 perf_gnt_cnt_o
);

   localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int unsigned OCC_W = $clog2(MAX_OUTSTANDING + 1);

   logic [ID_W-1:0]                       rr_ptr_q, rr_ptr_d;
   logic [MAX_OUTSTANDING-1:0][ID_W-1:0]  id_fifo_q, id_fifo_d;
   logic [PTR_W-1:0]                      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]                      rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0]                      occ_q, occ_d;
   logic                                  err_q, err_d;

   logic [ID_W-1:0] winner;
   logic [ID_W-1:0] scan_idx;
   logic [ID_W-1:0] head;
   logic            any_req, full, empty, push, pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Scan downwards so the lowest offset from rr_ptr wins
   always_comb begin
      winner   = '0;
      scan_idx = '0;
      for (int i = NB_IN_CHAN - 1; i >= 0; i--) begin
         scan_idx = ID_W'((int'(rr_ptr_q) + i) % NB_IN_CHAN);
         if (in_req_i[scan_idx]) winner = scan_idx;
      end
   end

   assign any_req   = |in_req_i;
   assign full      = (occ_q == OCC_W'(MAX_OUTSTANDING));
   assign empty     = (occ_q == '0);
   assign out_req_o = any_req & ~full;
   assign push      = out_req_o & out_gnt_i;
   assign pop       = out_r_valid_i & ~empty;
   assign head      = id_fifo_q[rd_ptr_q];

   assign out_add_o  = any_req ? in_add_i[winner]  : '0;
   assign out_wen_o  = any_req ? in_wen_i[winner]  : 1'b0;
   assign out_be_o   = any_req ? in_be_i[winner]   : '0;
   assign out_data_o = any_req ? in_data_i[winner] : '0;

   always_comb begin
      in_gnt_o     = '0;
      in_r_valid_o = '0;
      in_r_data_o  = '0;
      if (push) in_gnt_o[winner] = 1'b1;
      if (pop) begin
         in_r_valid_o[head] = 1'b1;
         in_r_data_o[head]  = out_r_data_i;
      end
   end

   always_comb begin
      rr_ptr_d  = rr_ptr_q;
      id_fifo_d = id_fifo_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      occ_d     = occ_q;
      err_d     = err_q;
      if (clear_i) begin
         rr_ptr_d  = '0;
         id_fifo_d = '0;
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         occ_d     = '0;
         err_d     = 1'b0;
      end else begin
         if (push) begin
            id_fifo_d[wr_ptr_q] = winner;
            wr_ptr_d            = ptr_inc(wr_ptr_q);
            rr_ptr_d            = (winner == ID_W'(NB_IN_CHAN - 1)) ? '0 : winner + ID_W'(1);
         end
         if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
         if (push && !pop) occ_d = occ_q + OCC_W'(1);
         if (pop && !push) occ_d = occ_q - OCC_W'(1);
         if (out_r_valid_i && empty) err_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_ptr_q  <= '0;
         id_fifo_q <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         occ_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         rr_ptr_q  <= rr_ptr_d;
         id_fifo_q <= id_fifo_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         occ_q     <= occ_d;
         err_q     <= err_d;
      end
   end

   assign idle_o = empty;
   assign err_o  = err_q;

`ifdef HWPE_STREAM_TCDM_ARB_PERF_CNT_EN
   logic [31:0] perf_cnt_q, perf_cnt_d;

   always_comb begin
      perf_cnt_d = perf_cnt_q;
      if (clear_i)   perf_cnt_d = '0;
      else if (push) perf_cnt_d = perf_cnt_q + 32'd1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) perf_cnt_q <= '0;
      else         perf_cnt_q <= perf_cnt_d;
   end

   assign perf_gnt_cnt_o = perf_cnt_q;
`else
   assign perf_gnt_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_hwpe_stream_tcdm_rr_arbiter.sv
// tb/tb_hwpe_stream_tcdm_rr_arbiter.sv - directed-vector bench for hwpe_stream_tcdm_rr_arbiter
module tb_hwpe_stream_tcdm_rr_arbiter;

   logic             clk_i = 1'b0;
   logic             rst_ni;
   logic             clear_i;
   logic [3:0]       in_req_i;
   logic [3:0][31:0] in_add_i;
   logic [3:0]       in_wen_i;
   logic [3:0][3:0]  in_be_i;
   logic [3:0][31:0] in_data_i;
   logic [3:0]       in_gnt_o;
   logic [3:0][31:0] in_r_data_o;
   logic [3:0]       in_r_valid_o;
   logic             out_req_o;
   logic [31:0]      out_add_o;
   logic             out_wen_o;
   logic [3:0]       out_be_o;
   logic [31:0]      out_data_o;
   logic             out_gnt_i;
   logic [31:0]      out_r_data_i;
   logic             out_r_valid_i;
   logic             idle_o;
   logic             err_o;
   logic [31:0]      perf_gnt_cnt_o;

   int n_vec = 0;
   int n_err = 0;

   hwpe_stream_tcdm_rr_arbiter #(.NB_IN_CHAN(4), .MAX_OUTSTANDING(4)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
      .in_req_i(in_req_i), .in_add_i(in_add_i), .in_wen_i(in_wen_i),
      .in_be_i(in_be_i), .in_data_i(in_data_i), .in_gnt_o(in_gnt_o),
      .in_r_data_o(in_r_data_o), .in_r_valid_o(in_r_valid_o),
      .out_req_o(out_req_o), .out_add_o(out_add_o), .out_wen_o(out_wen_o),
      .out_be_o(out_be_o), .out_data_o(out_data_o), .out_gnt_i(out_gnt_i),
      .out_r_data_i(out_r_data_i), .out_r_valid_i(out_r_valid_i),
      .idle_o(idle_o), .err_o(err_o), .perf_gnt_cnt_o(perf_gnt_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      logic [3:0]  exp_gnt;
      logic [3:0]  exp_rv;
      int          ch;
      logic [31:0] exp_perf;

      rst_ni        = 1'b0;
      clear_i       = 1'b0;
      in_req_i      = '0;
      in_wen_i      = 4'b1111;
      out_gnt_i     = 1'b0;
      out_r_data_i  = '0;
      out_r_valid_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_add_i[i]  = 32'hA000_0000 + 32'(i * 16);
         in_data_i[i] = 32'h5000_0000 + 32'(i);
         in_be_i[i]   = 4'(1 << i);
      end
      step();
      step();
      rst_ni = 1'b1;
      #1;

      // reset state
      check_vec("rst_idle", 32'(idle_o), 32'd1);
      check_vec("rst_err", 32'(err_o), 32'd0);
      check_vec("rst_req", 32'(out_req_o), 32'd0);
      check_vec("rst_add", out_add_o, 32'd0);
      check_vec("rst_gnt", 32'(in_gnt_o), 32'd0);
      check_vec("rst_rvalid", 32'(in_r_valid_o), 32'd0);
      check_vec("rst_perf", perf_gnt_cnt_o, 32'd0);

      // single requester ch2 stalled three cycles, then granted
      in_req_i = 4'b0100;
      for (int c = 0; c < 4; c++) begin
         out_gnt_i = (c == 3);
         #1;
         check_vec("t2_add", out_add_o, 32'hA000_0020);
         check_vec("t2_be", 32'(out_be_o), 32'h4);
         check_vec("t2_gnt", 32'(in_gnt_o), (c == 3) ? 32'h4 : 32'h0);
         step();
      end
      in_req_i      = '0;
      out_gnt_i     = 1'b0;
      out_r_valid_i = 1'b1;
      out_r_data_i  = 32'hCAFE_0002;
      #1;
      check_vec("t2_rvalid", 32'(in_r_valid_o), 32'h4);
      check_vec("t2_rdata", in_r_data_o[2], 32'hCAFE_0002);
      step();
      out_r_valid_i = 1'b0;
      in_req_i      = 4'b1111;
      #1;
      check_vec("t2_rrptr3", out_add_o, 32'hA000_0030);
      check_vec("t2_idle", 32'(idle_o), 32'd1);
      in_req_i = '0;
      clear_i  = 1'b1;
      step();
      clear_i = 1'b0;

      // all requesting, response latency 2
      for (int t = 0; t < 10; t++) begin
         in_req_i      = (t < 8) ? 4'b1111 : 4'b0000;
         out_gnt_i     = (t < 8);
         out_r_valid_i = (t >= 2);
         out_r_data_i  = 32'hD000_0000 + 32'(t - 2);
         #1;
         exp_gnt = (t < 8) ? 4'(1 << (t % 4)) : 4'b0000;
         check_vec($sformatf("t1_gnt%0d", t), 32'(in_gnt_o), 32'(exp_gnt));
         if (t >= 2) begin
            ch = (t - 2) % 4;
            check_vec($sformatf("t1_rv%0d", t), 32'(in_r_valid_o), 32'(1 << ch));
            check_vec($sformatf("t1_rd%0d", t), in_r_data_o[ch], 32'hD000_0000 + 32'(t - 2));
         end
         step();
      end
      out_r_valid_i = 1'b0;
      out_gnt_i     = 1'b0;
      #1;
      check_vec("t1_idle", 32'(idle_o), 32'd1);

      // fill to MAX_OUTSTANDING with no responses
      in_req_i  = 4'b1111;
      out_gnt_i = 1'b1;
      for (int c = 0; c < 6; c++) begin
         #1;
         check_vec($sformatf("t3_req%0d", c), 32'(out_req_o), (c < 4) ? 32'd1 : 32'd0);
         check_vec($sformatf("t3_gnt%0d", c), 32'(in_gnt_o), (c < 4) ? 32'(1 << c) : 32'd0);
         step();
      end
      check_vec("t3_idle", 32'(idle_o), 32'd0);
      out_r_valid_i = 1'b1;
      out_r_data_i  = 32'hE000_0000;
      #1;
      check_vec("t3_full_req", 32'(out_req_o), 32'd0);
      check_vec("t3_rv", 32'(in_r_valid_o), 32'h1);
      check_vec("t3_rd", in_r_data_o[0], 32'hE000_0000);
      step();
      out_r_valid_i = 1'b0;
      #1;
      check_vec("t3_regnt", 32'(in_gnt_o), 32'h1);
      step();
      in_req_i  = '0;
      out_gnt_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         out_r_valid_i = 1'b1;
         out_r_data_i  = 32'hE000_0010 + 32'(k);
         #1;
         ch = (k + 1) % 4;
         check_vec($sformatf("t3_drv%0d", k), 32'(in_r_valid_o), 32'(1 << ch));
         check_vec($sformatf("t3_drd%0d", k), in_r_data_o[ch], 32'hE000_0010 + 32'(k));
         step();
      end
      out_r_valid_i = 1'b0;
      #1;
      check_vec("t3_idle_end", 32'(idle_o), 32'd1);
      check_vec("t3_err", 32'(err_o), 32'd0);

      // unexpected response after reset
      rst_ni = 1'b0;
      step();
      rst_ni = 1'b1;
      out_r_valid_i = 1'b1;
      out_r_data_i  = 32'hBAD0_BAD0;
      #1;
      check_vec("t4_rv", 32'(in_r_valid_o), 32'd0);
      check_vec("t4_rd", in_r_data_o[0], 32'd0);
      check_vec("t4_err_pre", 32'(err_o), 32'd0);
      step();
      out_r_valid_i = 1'b0;
      #1;
      check_vec("t4_err", 32'(err_o), 32'd1);
      check_vec("t4_idle", 32'(idle_o), 32'd1);
      clear_i = 1'b1;
      step();
      clear_i = 1'b0;
      #1;
      check_vec("t4_err_clr", 32'(err_o), 32'd0);

      // reads from ch1, ch3, ch0 answered with latencies 1, 3, 7
      for (int c = 0; c < 10; c++) begin
         in_req_i      = (c == 0) ? 4'b0010 : (c == 1) ? 4'b1000 : (c == 2) ? 4'b0001 : 4'b0000;
         out_gnt_i     = 1'b1;
         out_r_valid_i = (c == 1) || (c == 4) || (c == 9);
         out_r_data_i  = 32'h7700_0000 + 32'(c);
         #1;
         check_vec($sformatf("t5_gnt%0d", c), 32'(in_gnt_o), 32'(in_req_i));
         exp_rv = (c == 1) ? 4'b0010 : (c == 4) ? 4'b1000 : (c == 9) ? 4'b0001 : 4'b0000;
         check_vec($sformatf("t5_rv%0d", c), 32'(in_r_valid_o), 32'(exp_rv));
         if (c == 1) check_vec("t5_rd1", in_r_data_o[1], 32'h7700_0001);
         if (c == 4) check_vec("t5_rd3", in_r_data_o[3], 32'h7700_0004);
         if (c == 9) check_vec("t5_rd0", in_r_data_o[0], 32'h7700_0009);
         step();
      end
      out_r_valid_i = 1'b0;
      out_gnt_i     = 1'b0;
      #1;
      check_vec("t5_idle", 32'(idle_o), 32'd1);
      check_vec("t5_err", 32'(err_o), 32'd0);

      // asynchronous reset with three outstanding
      clear_i = 1'b1;
      step();
      clear_i   = 1'b0;
      in_req_i  = 4'b1111;
      out_gnt_i = 1'b1;
      for (int c = 0; c < 3; c++) step();
      in_req_i  = '0;
      out_gnt_i = 1'b0;
      #1;
      check_vec("t6_busy", 32'(idle_o), 32'd0);
      #2;
      rst_ni = 1'b0;
      #1;
      check_vec("t6_rst_idle", 32'(idle_o), 32'd1);
      in_req_i = 4'b1111;
      #1;
      check_vec("t6_rst_rrptr", out_add_o, 32'hA000_0000);
      step();
      rst_ni = 1'b1;
      #1;
      check_vec("t6_perf0", perf_gnt_cnt_o, 32'd0);
      out_gnt_i = 1'b1;
      for (int c = 0; c < 10; c++) begin
         out_r_valid_i = (c >= 1);
         out_r_data_i  = 32'h6600_0000 + 32'(c);
         step();
      end
      in_req_i      = '0;
      out_gnt_i     = 1'b0;
      out_r_valid_i = 1'b1;
`ifdef HWPE_STREAM_TCDM_ARB_PERF_CNT_EN
      exp_perf = 32'd10;
`else
      exp_perf = 32'd0;
`endif
      #1;
      check_vec("t6_perf10", perf_gnt_cnt_o, exp_perf);
      check_vec("t6_last_rv", 32'(in_r_valid_o), 32'h2);
      step();
      out_r_valid_i = 1'b0;
      #1;
      check_vec("t6_idle", 32'(idle_o), 32'd1);
      check_vec("t6_err", 32'(err_o), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
